// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
//   XLEN_DEF      default instruction/address width
//   RESET_PC_DEF  default first fetch address
//   NOP           ARM "MOV r0, r0" encoding
//   fetch_entry_t one buffered instruction word with its address
package fetch_pkg;

  localparam int unsigned XLEN_DEF     = 32;
  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
  localparam logic [31:0] NOP          = 32'hE1A0_0000;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO of fetch_entry_t with registered storage (no bypass).
//   clk, reset   clock, synchronous active-low reset
//   push         write push_data (ignored when full unless popping)
//   pop          drop the head (ignored when empty)
//   flush        empty the FIFO at this edge; wins over push/pop
//   head         current head entry (stale contents when empty)
//   count        number of valid entries
//   full, empty  occupancy flags
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int unsigned DEPTH = 2,
  localparam int unsigned AW = $clog2(DEPTH),
  localparam int unsigned CW = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  fetch_entry_t  push_data,
  input  logic          pop,
  input  logic          flush,
  output fetch_entry_t  head,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
);

  fetch_entry_t  mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic          do_push;
  logic          do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr];

  // DEPTH is a power of two, so the pointers wrap naturally.
  always_ff @(posedge clk) begin
    if (!reset || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  // Storage needs no reset; count gates visibility.
  always_ff @(posedge clk) begin
    if (reset && !flush && do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: issues word fetches, buffers in-order responses and
// hands {instr, pc} downstream. A redirect flushes the buffer and marks every
// outstanding request as stale so its response is dropped.
//   clk, reset                       clock, synchronous active-low reset
//   imem_req_valid/ready/addr        fetch request channel
//   imem_rsp_valid/data              in-order response channel
//   instr_valid/ready, instr         downstream instruction handshake
//   instr_pc, pc_plus8               head address and head address + 8
//   redirect, redirect_target        PC change; target low bits ignored
module instr_fetch_unit
  import fetch_pkg::*;
#(
  parameter int unsigned     XLEN     = XLEN_DEF,
  parameter int unsigned     DEPTH    = 2,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(RESET_PC_DEF)
) (
  input  logic            clk,
  input  logic            reset,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [XLEN-1:0] imem_rsp_data,
  output logic            instr_valid,
  input  logic            instr_ready,
  output logic [XLEN-1:0] instr,
  output logic [XLEN-1:0] instr_pc,
  output logic [XLEN-1:0] pc_plus8,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirect_target
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic [XLEN-1:0] fetch_pc;
  logic [CW-1:0]   inflight;
  logic [CW-1:0]   discard;
  logic [CW-1:0]   inflight_next;
  logic [CW:0]     occupancy;

  fetch_entry_t    fifo_head, fifo_entry;
  fetch_entry_t    pcq_head, pcq_entry;
  logic [CW-1:0]   fifo_count, pcq_count;
  logic            fifo_full, fifo_empty, pcq_full, pcq_empty;

  logic            pop, accept, rsp, drop, push;
  logic            unused_bits;

  assign pop = !fifo_empty && instr_ready;

  // A head leaving this cycle frees its slot now, which lets a 1-cycle memory
  // sustain one instruction per cycle. pcq_full is a redundant safety guard.
  assign occupancy      = {1'b0, fifo_count} + {1'b0, inflight} - (CW+1)'(pop);
  assign imem_req_valid = reset && !redirect && !pcq_full && (occupancy < (CW+1)'(DEPTH));
  assign imem_req_addr  = fetch_pc;

  assign accept = imem_req_valid && imem_req_ready;
  // Responses with nothing outstanding are ignored entirely.
  assign rsp    = imem_rsp_valid && (inflight != '0);
  assign drop   = redirect || (discard != '0);
  assign push   = rsp && !drop;

  assign inflight_next = inflight + CW'(accept) - CW'(rsp);

  assign pcq_entry  = {32'h0, 32'(fetch_pc)};
  assign fifo_entry = {32'(imem_rsp_data), pcq_head.pc};

  always_ff @(posedge clk) begin
    if (!reset) begin
      fetch_pc <= RESET_PC;
      inflight <= '0;
      discard  <= '0;
    end else begin
      inflight <= inflight_next;
      if (redirect) begin
        fetch_pc <= {redirect_target[XLEN-1:2], 2'b00};
        // Everything still outstanding after this edge is wrong-path.
        discard  <= inflight_next;
      end else begin
        if (accept) fetch_pc <= fetch_pc + XLEN'(4);
        if (rsp && (discard != '0)) discard <= discard - CW'(1);
      end
    end
  end

  // Addresses of outstanding requests; one entry retires per response.
  fetch_fifo #(
    .DEPTH (DEPTH)
  ) u_pc_queue (
    .clk       (clk),
    .reset     (reset),
    .push      (accept),
    .push_data (pcq_entry),
    .pop       (rsp),
    .flush     (1'b0),
    .head      (pcq_head),
    .count     (pcq_count),
    .full      (pcq_full),
    .empty     (pcq_empty)
  );

  fetch_fifo #(
    .DEPTH (DEPTH)
  ) u_instr_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data (fifo_entry),
    .pop       (pop),
    .flush     (redirect),
    .head      (fifo_head),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign instr_valid = !fifo_empty;
  assign instr       = fifo_empty ? '0 : XLEN'(fifo_head.instr);
  assign instr_pc    = fifo_empty ? '0 : XLEN'(fifo_head.pc);
  assign pc_plus8    = instr_pc + XLEN'(8);

  assign unused_bits = ^{fifo_full, pcq_empty, pcq_count, pcq_head.instr, redirect_target[1:0]};

endmodule
